// File: rtl/button_events_if.sv
// Button gesture bus: debounced press/release pulses in, gesture pulses out.
interface button_events_if;
  logic pb_down;
  logic pb_up;
  logic click;
  logic dclick;
  logic long_press;
  logic repeat_pulse;
  logic held;

  // Producer side: drives the debounced button pulses, observes gestures.
  modport master (
    output pb_down, pb_up,
    input  click, dclick, long_press, repeat_pulse, held
  );

  // Decoder side: consumes button pulses, produces gestures.
  modport slave (
    input  pb_down, pb_up,
    output click, dclick, long_press, repeat_pulse, held
  );
endinterface

// File: rtl/button_events.sv
// Push-button gesture decoder: classifies debounced press/release pulses
// into single click, double click and long press, with auto-repeat while
// a long press is held. All outputs are registered.
module button_events #(
  parameter int LONG_TICKS   = 8000000,
  parameter int DCLICK_TICKS = 4000000,
  parameter int REPEAT_DELAY = 6000000,
  parameter int REPEAT_RATE  = 1500000,
  parameter int CNT_W        = 24
) (
  input logic            clk,
  input logic            rst,
  button_events_if.slave bus
);

  localparam longint CNT_LIM = longint'(1) << CNT_W;

  if (LONG_TICKS < 2 || longint'(LONG_TICKS) >= CNT_LIM ||
      DCLICK_TICKS < 2 || longint'(DCLICK_TICKS) >= CNT_LIM ||
      REPEAT_DELAY < 2 || longint'(REPEAT_DELAY) >= CNT_LIM ||
      REPEAT_RATE < 2 || longint'(REPEAT_RATE) >= CNT_LIM) begin : g_bad_params
    $error("button_events: every tick parameter must be >= 2 and < 2**CNT_W");
  end

  // Terminal counts: the timer starts at 0 on state entry, so a wait of N
  // cycles ends when it reads N-1.
  localparam logic [CNT_W-1:0] LONG_END   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_END = CNT_W'(DCLICK_TICKS - 1);
  localparam logic [CNT_W-1:0] RDELAY_END = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RRATE_END  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             first_rep, first_rep_nxt;
  logic             click_q, dclick_q, long_q, rep_q, held_q;
  logic             click_nxt, dclick_nxt, long_nxt, rep_nxt, held_nxt;
  logic             dn, up;
  logic [CNT_W-1:0] rep_end;

  // Simultaneous press and release cannot come from the debouncer; such a
  // cycle is treated as carrying no button event at all.
  assign dn      = bus.pb_down & ~bus.pb_up;
  assign up      = bus.pb_up & ~bus.pb_down;
  assign rep_end = first_rep ? RDELAY_END : RRATE_END;

  // Next-state, timer and gesture pulse decode.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + 1'b1;
    first_rep_nxt = first_rep;
    click_nxt     = 1'b0;
    dclick_nxt    = 1'b0;
    long_nxt      = 1'b0;
    rep_nxt       = 1'b0;
    unique case (state)
      IDLE: begin
        // Timer parked at zero while idle so it never wraps.
        cnt_nxt = '0;
        if (dn) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (up) begin
          state_nxt = WAIT2;
        end else if (cnt == LONG_END) begin
          long_nxt      = 1'b1;
          first_rep_nxt = 1'b1;
          state_nxt     = LONG;
        end
      end
      WAIT2: begin
        if (dn) begin
          state_nxt = PRESS2;
        end else if (cnt == DCLICK_END) begin
          click_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      PRESS2: begin
        // No timeout here; holding the timer keeps an endless hold from wrapping.
        cnt_nxt = cnt;
        if (up) begin
          dclick_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      LONG: begin
        if (up) begin
          state_nxt = IDLE;
        end else if (cnt == rep_end) begin
          rep_nxt       = 1'b1;
          cnt_nxt       = '0;
          first_rep_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
    held_nxt = (state_nxt == PRESS1) || (state_nxt == PRESS2) || (state_nxt == LONG);
  end

  // State, timer and registered outputs; reset drops any pending gesture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      first_rep <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      first_rep <= first_rep_nxt;
      click_q   <= click_nxt;
      dclick_q  <= dclick_nxt;
      long_q    <= long_nxt;
      rep_q     <= rep_nxt;
      held_q    <= held_nxt;
    end
  end

  assign bus.click        = click_q;
  assign bus.dclick       = dclick_q;
  assign bus.long_press   = long_q;
  assign bus.repeat_pulse = rep_q;
  assign bus.held         = held_q;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with small tick parameters.
module tb_button_events;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_events_if bus ();

  button_events #(
    .LONG_TICKS  (8),
    .DCLICK_TICKS(5),
    .REPEAT_DELAY(6),
    .REPEAT_RATE (3),
    .CNT_W       (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Output bit order: {click, dclick, long_press, repeat_pulse, held}
  localparam logic [4:0] C  = 5'b10000;
  localparam logic [4:0] DC = 5'b01000;
  localparam logic [4:0] LP = 5'b00100;
  localparam logic [4:0] RP = 5'b00010;
  localparam logic [4:0] H  = 5'b00001;
  localparam logic [4:0] Z  = 5'b00000;

  typedef struct {
    string      name;
    int         n;
    logic       r;
    logic       d;
    logic       u;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input string name, input int n, input logic r,
                     input logic d, input logic u, input logic [4:0] exp);
    vec_t v;
    v.name = name; v.n = n; v.r = r; v.d = d; v.u = u; v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic logic [4:0] outs();
    return {bus.click, bus.dclick, bus.long_press, bus.repeat_pulse, bus.held};
  endfunction

  initial begin
    int lp_at;
    int rp_at;
    int cyc;

    rst = 1'b1;
    bus.pb_down = 1'b0;
    bus.pb_up   = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    add("rst_hold", 2, 1, 0, 0, Z);
    add("rst_rel",  2, 0, 0, 0, Z);
    // Single click: down@0 up@3 -> click@9
    add("sc",  1, 0, 1, 0, Z);
    add("sc",  2, 0, 0, 0, H);
    add("sc",  1, 0, 0, 1, H);
    add("sc",  5, 0, 0, 0, Z);
    add("sc",  1, 0, 0, 0, C);
    add("sc",  2, 0, 0, 0, Z);
    // Double click: down@0 up@3 down@6 up@9 -> dclick@10
    add("dc",  1, 0, 1, 0, Z);
    add("dc",  2, 0, 0, 0, H);
    add("dc",  1, 0, 0, 1, H);
    add("dc",  2, 0, 0, 0, Z);
    add("dc",  1, 0, 1, 0, Z);
    add("dc",  2, 0, 0, 0, H);
    add("dc",  1, 0, 0, 1, H);
    add("dc",  1, 0, 0, 0, DC);
    add("dc",  6, 0, 0, 0, Z);
    // Long press with repeat: down@0 up@30
    add("lp",  1, 0, 1, 0, Z);
    add("lp",  8, 0, 0, 0, H);
    add("lp",  1, 0, 0, 0, LP | H);
    add("lp",  5, 0, 0, 0, H);
    add("lp",  1, 0, 0, 0, RP | H);
    add("lp",  2, 0, 0, 0, H);
    add("lp",  1, 0, 0, 0, RP | H);
    add("lp",  2, 0, 0, 0, H);
    add("lp",  1, 0, 0, 0, RP | H);
    add("lp",  2, 0, 0, 0, H);
    add("lp",  1, 0, 0, 0, RP | H);
    add("lp",  2, 0, 0, 0, H);
    add("lp",  1, 0, 0, 0, RP | H);
    add("lp",  2, 0, 0, 0, H);
    add("lp",  1, 0, 0, 1, RP | H);
    add("lp",  8, 0, 0, 0, Z);
    // Release at LONG_TICKS is still short: down@0 up@8 -> click@14
    add("bnd8", 1, 0, 1, 0, Z);
    add("bnd8", 7, 0, 0, 0, H);
    add("bnd8", 1, 0, 0, 1, H);
    add("bnd8", 5, 0, 0, 0, Z);
    add("bnd8", 1, 0, 0, 0, C);
    add("bnd8", 3, 0, 0, 0, Z);
    // Release one cycle later ends a long press: down@0 up@9
    add("bnd9", 1, 0, 1, 0, Z);
    add("bnd9", 8, 0, 0, 0, H);
    add("bnd9", 1, 0, 0, 1, LP | H);
    add("bnd9", 10, 0, 0, 0, Z);
    // Second press on the last legal gap cycle: down@0 up@3 down@8 up@10
    add("gap",  1, 0, 1, 0, Z);
    add("gap",  2, 0, 0, 0, H);
    add("gap",  1, 0, 0, 1, H);
    add("gap",  4, 0, 0, 0, Z);
    add("gap",  1, 0, 1, 0, Z);
    add("gap",  1, 0, 0, 0, H);
    add("gap",  1, 0, 0, 1, H);
    add("gap",  1, 0, 0, 0, DC);
    add("gap",  6, 0, 0, 0, Z);
    // Press in the click cycle starts a fresh gesture: click@9 with down@9
    add("cpr",  1, 0, 1, 0, Z);
    add("cpr",  2, 0, 0, 0, H);
    add("cpr",  1, 0, 0, 1, H);
    add("cpr",  5, 0, 0, 0, Z);
    add("cpr",  1, 0, 1, 0, C);
    add("cpr",  1, 0, 0, 0, H);
    add("cpr",  1, 0, 0, 1, H);
    add("cpr",  5, 0, 0, 0, Z);
    add("cpr",  1, 0, 0, 0, C);
    add("cpr",  2, 0, 0, 0, Z);
    // Reset mid-press: down@0 rst@4 up@6 -> nothing
    add("rmid", 1, 0, 1, 0, Z);
    add("rmid", 3, 0, 0, 0, H);
    add("rmid", 1, 1, 0, 0, H);
    add("rmid", 1, 0, 0, 0, Z);
    add("rmid", 1, 0, 0, 1, Z);
    add("rmid", 14, 0, 0, 0, Z);
    // Illegal simultaneous press/release in IDLE is ignored
    add("ill",  1, 0, 1, 1, Z);
    add("ill",  12, 0, 0, 0, Z);
    // Illegal pair while pressed is ignored too: down@0, both@3 -> long@9
    add("illp", 1, 0, 1, 0, Z);
    add("illp", 2, 0, 0, 0, H);
    add("illp", 1, 0, 1, 1, H);
    add("illp", 5, 0, 0, 0, H);
    add("illp", 1, 0, 0, 1, LP | H);
    add("illp", 8, 0, 0, 0, Z);

    // Apply each row for n cycles; outputs checked #1 after the edge.
    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        tests++;
        if (outs() !== vecs[i].exp) begin
          fails++;
          $display("FAIL %s row %0d cyc %0d: outs=%b expected=%b", vecs[i].name, i, k,
                   outs(), vecs[i].exp);
        end
        rst         = vecs[i].r;
        bus.pb_down = vecs[i].d;
        bus.pb_up   = vecs[i].u;
        @(posedge clk);
        #1;
      end
    end

    // Hand sequence: bounded wait for long_press and first repeat on a hold.
    rst = 1'b0;
    bus.pb_down = 1'b1;
    bus.pb_up   = 1'b0;
    lp_at = -1;
    rp_at = -1;
    cyc   = 0;
    while (cyc < 40 && rp_at < 0) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.pb_down = 1'b0;
      if (bus.long_press && lp_at < 0) lp_at = cyc;
      if (bus.repeat_pulse) rp_at = cyc;
    end
    tests++;
    if (lp_at != 9) begin
      fails++;
      $display("FAIL hold_long_cycle: got %0d expected 9", lp_at);
    end
    tests++;
    if (rp_at != 15) begin
      fails++;
      $display("FAIL hold_first_repeat: got %0d expected 15", rp_at);
    end
    // Release coinciding with a repeat timeout: release wins, no further pulse.
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.pb_up = 1'b1;
    @(posedge clk);
    #1;
    bus.pb_up = 1'b0;
    tests++;
    if (outs() !== Z) begin
      fails++;
      $display("FAIL hold_release: outs=%b expected=%b", outs(), Z);
    end
    repeat (10) begin
      @(posedge clk);
      #1;
      tests++;
      if (outs() !== Z) begin
        fails++;
        $display("FAIL hold_after_release: outs=%b expected=%b", outs(), Z);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
